mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
- Upstream stage for the multiply-accumulate unit.
- Accepts operand pairs from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one pair per cycle as a single-cycle strobe that drives the MAC's a/b/valid_in inputs.
- Counts pairs per vector (delimited by a last flag), reports vector length on completion, and supports hold (stall) and synchronous flush.

Parameters:
- DATA_W, 16, operand width; must match the MAC operand width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the per-vector pair counter and vec_len.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_a  in  DATA_W  operand A from the producer.
- s_b  in  DATA_W  operand B from the producer.
- s_last  in  1  marks the final pair of a vector.
- s_valid  in  1  producer has a pair.
- s_ready  out  1  feeder can accept a pair (FIFO not full).
- stall  in  1  downstream hold; no issue while high.
- flush  in  1  synchronous discard of all buffered pairs and counter state.
- m_a  out  DATA_W  issued operand A (drives the MAC a input).
- m_b  out  DATA_W  issued operand B (drives the MAC b input).
- m_valid  out  1  single-cycle issue strobe (drives the MAC valid_in input).
- m_last  out  1  issued pair is the last of its vector; qualified by m_valid.
- vec_done  out  1  one-cycle pulse coincident with the issue of a last pair.
- vec_len  out  CNT_W  pair count of the most recently completed vector; holds until the next completion.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-high):
  - FIFO empty; level=0; s_ready=1.
  - m_a=0, m_b=0, m_valid=0, m_last=0, vec_done=0, vec_len=0.
  - Pair counter=0.
- Push:
  - Occurs when s_valid && s_ready. {s_a, s_b, s_last} is written at the write pointer.
  - s_ready = (level != DEPTH), driven combinationally from registered level.
  - When full, s_ready=0 even if a pop occurs the same cycle. No same-cycle push-through at full.
- Pop/issue:
  - Occurs when level != 0 && !stall && !flush.
  - The entry at the read pointer is registered into m_a/m_b/m_last, and m_valid=1 the following cycle.
  - Otherwise m_valid=0 and m_last=0; m_a/m_b hold their last values.
- Latency:
  - A pair pushed into an empty FIFO at edge N is issued (m_valid=1) after edge N+1.
  - Back-to-back pushes with stall low give one issue per cycle, in order.
- Simultaneous push and pop (not full): level unchanged; both pointers advance.
- Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH.
- Pair counter:
  - Increments on every issue.
  - On issue of an entry with last=1:
    - vec_len <= counter+1 (saturated), registered alongside the issue.
    - vec_done=1 in the same cycle as m_valid/m_last.
    - Counter cleared to 0.
  - Saturates at 2^CNT_W-1; it does not wrap.
- Stall:
  - While stall=1, no pop occurs and m_valid=0 from the next cycle.
  - Pushes continue until full.
- Flush:
  - Priority over push and pop in the same cycle.
  - Next cycle: level=0, pointers equal, m_valid=0, m_last=0, vec_done=0, counter=0.
  - vec_len retains its value.
  - s_ready=1 in the cycle after flush.
- Producer rule: s_a/s_b/s_last must hold stable while s_valid=1 && s_ready=0. The feeder does not check this.
- Reset mid-operation: all buffered pairs are lost and outputs return immediately to reset values.

Decomposition:
- Shared package mac_pkg:
  - DATA_W, default 16.
  - PROD_W = 2*DATA_W.
  - Packed struct operand_pair_t {a, b, last}.
- One natural sub-module: mac_sync_fifo.
  - Parameterised width and depth.
  - Push/pop/flush inputs; full/empty/level outputs.
  - Async active-high reset on clk/reset.
- The feeder top holds the issue register, stall/flush gating and the pair counter.

Test Plan:
- Basic issue: after reset, push (3,4,last=0), (5,6,last=1) in consecutive cycles with stall=0 -> m_valid in the next two cycles with m_a/m_b=3/4 then 5/6; m_last and vec_done high on the second; vec_len=2.
- Fill/backpressure: stall=1, push 9 pairs (values 1..9) -> s_ready drops after 8 accepted, level=8, 9th held. Release stall -> 1..9 issued in order on consecutive cycles with no gaps; s_ready returns to 1 the cycle after the first pop.
- Stall mid-stream: 4 pairs buffered, stall pulsed high for 3 cycles after the 2nd issue -> m_valid=0 for exactly 3 cycles, then pairs 3 and 4 issue; no duplicates or drops.
- Flush: 5 pairs buffered, last vec_len=2, flush=1 with s_valid=1 the same cycle -> next cycle level=0, m_valid=0, counter=0, vec_len=2; no further issue until a new push.
- Wrap-around: 20 pairs of a single vector (last on the 20th), with random 1-cycle stalls -> exact order preserved across pointer wrap; vec_done once; vec_len=20.
- Async reset mid-vector: 3 pairs issued, 2 buffered, reset asserted between edges -> outputs zero immediately; level=0, s_ready=1; after release, a fresh vector of length 1 gives vec_len=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types for the multiply-accumulate datapath.
// The operand pair is the unit of transfer into the MAC.
package mac_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              last;
  } operand_pair_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Producer-side handshake and MAC-side issue bundle of the operand feeder.
// The master drives operands and control; the slave is the feeder.
interface mac_operand_feeder_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] s_a;
  logic [DATA_W-1:0] s_b;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] m_a;
  logic [DATA_W-1:0] m_b;
  logic              m_valid;
  logic              m_last;
  logic              vec_done;
  logic [CNT_W-1:0]  vec_len;
  logic [LW-1:0]     level;

  modport master (
    output s_a, s_b, s_last, s_valid, stall, flush,
    input  s_ready, m_a, m_b, m_valid, m_last,
    input  vec_done, vec_len, level
  );

  modport slave (
    input  s_a, s_b, s_last, s_valid, stall, flush,
    output s_ready, m_a, m_b, m_valid, m_last,
    output vec_done, vec_len, level
  );

endinterface

// File: rtl/mac_sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry.
// Flush wins over push and pop; a full FIFO refuses pushes outright.
module mac_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_level <= r_level + 1'b1;
      else if (!w_push && w_pop)
        r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs and issues one per cycle to the MAC,
// tracking vector length via the last flag.
module mac_operand_feeder #(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 reset,
  mac_operand_feeder_if.slave bus
);

  import mac_pkg::*;

  localparam int W  = 2 * DATA_W + 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]      w_rdata;
  logic [W-1:0]      w_wdata;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic              w_pop;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] r_m_a;
  logic [DATA_W-1:0] r_m_b;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_vec_done;
  logic [CNT_W-1:0]  r_vec_len;
  logic [CNT_W-1:0]  r_cnt;

  assign w_wdata = {bus.s_a, bus.s_b, bus.s_last};
  assign w_pop   = !w_empty && !bus.stall && !bus.flush;

  // Counter parks at all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  mac_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.s_valid && bus.s_ready),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_a      <= '0;
      r_m_b      <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_vec_done <= 1'b0;
      r_vec_len  <= '0;
      r_cnt      <= '0;
    end else if (bus.flush) begin
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_vec_done <= 1'b0;
      r_cnt      <= '0;
    end else if (w_pop) begin
      r_m_a      <= w_rdata[W-1 -: DATA_W];
      r_m_b      <= w_rdata[DATA_W:1];
      r_m_valid  <= 1'b1;
      r_m_last   <= w_rdata[0];
      r_vec_done <= w_rdata[0];
      if (w_rdata[0]) begin
        r_vec_len <= w_cnt_inc;
        r_cnt     <= '0;
      end else begin
        r_cnt     <= w_cnt_inc;
      end
    end else begin
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_vec_done <= 1'b0;
    end
  end

  assign bus.s_ready  = !w_full;
  assign bus.m_a      = r_m_a;
  assign bus.m_b      = r_m_b;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_last   = r_m_last;
  assign bus.vec_done = r_vec_done;
  assign bus.vec_len  = r_vec_len;
  assign bus.level    = w_level;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: queue model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mac_operand_feeder;

  import mac_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  mac_operand_feeder_if #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) bus ();

  mac_operand_feeder #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model: the FIFO is a plain queue; issue registers mirror the head.
  operand_pair_t     q[$];
  logic [DW-1:0]     e_a, e_b;
  logic              e_v, e_l, e_d;
  logic [CW-1:0]     e_len, e_cnt;

  always @(posedge clk or posedge reset) begin
    bit            rdy;
    bit            pop;
    operand_pair_t p;
    if (reset) begin
      q.delete();
      e_a = 0; e_b = 0; e_v = 0; e_l = 0; e_d = 0;
      e_len = 0; e_cnt = 0;
    end else begin
      cyc++;
      rdy = (q.size() != DEPTH);
      pop = (q.size() != 0) && !bus.stall && !bus.flush;
      if (bus.flush) begin
        q.delete();
        e_v = 0; e_l = 0; e_d = 0; e_cnt = 0;
      end else begin
        e_v = 0; e_l = 0; e_d = 0;
        if (pop) begin
          p = q.pop_front();
          e_a = p.a; e_b = p.b; e_v = 1; e_l = p.last;
          if (e_cnt != {CW{1'b1}}) e_cnt = e_cnt + 1;
          if (p.last) begin
            e_d = 1; e_len = e_cnt; e_cnt = 0;
          end
        end
        if (bus.s_valid && rdy)
          q.push_back('{a: bus.s_a, b: bus.s_b, last: bus.s_last});
      end
    end
  end

  logic [DW-1:0] log_a[$], log_b[$];
  int            log_c[$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("m_valid", bus.m_valid, e_v);
      check("m_last", bus.m_last, e_l);
      check("vec_done", bus.vec_done, e_d);
      check("vec_len", bus.vec_len, e_len);
      check("m_a", bus.m_a, e_a);
      check("m_b", bus.m_b, e_b);
      check("level", bus.level, q.size());
      check("s_ready", bus.s_ready, q.size() != DEPTH);
      if (bus.m_valid) begin
        log_a.push_back(bus.m_a);
        log_b.push_back(bus.m_b);
        log_c.push_back(cyc);
      end
      if (bus.vec_done) done_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input int a, input int b, input bit l,
                      output int at);
    bit acc;
    int n;
    n = 0;
    bus.s_a = DW'(a); bus.s_b = DW'(b);
    bus.s_last = l; bus.s_valid = 1'b1;
    do begin
      acc = bus.s_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 60);
    check("push_accept", acc, 1);
    at = cyc;
    bus.s_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_a.delete(); log_b.delete(); log_c.delete();
  endtask

  task automatic chk_seq(input string nm, input int base, input int n);
    check({nm, "_count"}, log_a.size(), n);
    for (int i = 0; i < n && i < log_a.size(); i++) begin
      check({nm, "_a"}, log_a[i], base + i);
    end
  endtask

  int t0, t1, d0;

  initial begin
    bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0;
    bus.s_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    #1 reset = 1'b1;
    idle(2);
    check("rst_level", bus.level, 0);
    check("rst_ready", bus.s_ready, 1);
    check("rst_valid", bus.m_valid, 0);
    check("rst_vec_len", bus.vec_len, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // Basic issue
    clear_log();
    push(3, 4, 1'b0, t0);
    push(5, 6, 1'b1, t1);
    idle(3);
    check("basic_n", log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("basic_a0", log_a[0], 3);
      check("basic_b0", log_b[0], 4);
      check("basic_a1", log_a[1], 5);
      check("basic_b1", log_b[1], 6);
      check("basic_lat", log_c[0], t0 + 1);
      check("basic_b2b", log_c[1], log_c[0] + 1);
    end
    check("basic_vec_len", bus.vec_len, 2);
    check("basic_done", done_cnt, 1);

    // Fill and backpressure
    clear_log();
    bus.stall = 1'b1;
    fork
      begin
        for (int i = 1; i <= 9; i++) push(i, i + 50, i == 9, t0);
      end
      begin
        idle(12);
        check("fill_level", bus.level, 8);
        check("fill_ready", bus.s_ready, 0);
        check("fill_valid", bus.m_valid, 0);
        bus.stall = 1'b0;
        idle(1);
        check("fill_ready_back", bus.s_ready, 1);
      end
    join
    idle(12);
    chk_seq("fill", 1, 9);
    if (log_c.size() == 9)
      check("fill_no_gap", log_c[8] - log_c[0], 8);
    check("fill_vec_len", bus.vec_len, 9);

    // Stall mid-stream
    clear_log();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) push(11 + i, 0, i == 3, t0);
    check("mid_level", bus.level, 4);
    bus.stall = 1'b0;
    idle(2);
    bus.stall = 1'b1;
    idle(3);
    bus.stall = 1'b0;
    idle(4);
    chk_seq("mid", 11, 4);
    if (log_c.size() == 4) begin
      check("mid_gap", log_c[2] - log_c[1], 4);
      check("mid_tail", log_c[3] - log_c[2], 1);
    end
    check("mid_vec_len", bus.vec_len, 4);

    // Flush
    push(7, 7, 1'b0, t0);
    push(8, 8, 1'b1, t0);
    idle(4);
    check("pre_flush_len", bus.vec_len, 2);
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) push(30 + i, 0, 1'b0, t0);
    bus.s_a = 99; bus.s_b = 99; bus.s_last = 1'b1;
    bus.s_valid = 1'b1; bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0; bus.s_valid = 1'b0;
    check("flush_level", bus.level, 0);
    check("flush_valid", bus.m_valid, 0);
    check("flush_ready", bus.s_ready, 1);
    check("flush_len", bus.vec_len, 2);
    clear_log();
    bus.stall = 1'b0;
    idle(5);
    check("flush_quiet", log_a.size(), 0);
    push(40, 41, 1'b1, t0);
    idle(3);
    check("flush_cnt_clr", bus.vec_len, 1);

    // Wrap-around with sporadic single-cycle stalls
    clear_log();
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 20; i++) push(100 + i, 7, i == 19, t0);
      end
      begin
        for (int k = 0; k < 30; k++) begin
          bus.stall = !bus.stall && ($urandom_range(0, 3) == 0);
          idle(1);
        end
        bus.stall = 1'b0;
      end
    join
    idle(12);
    chk_seq("wrap", 100, 20);
    check("wrap_done", done_cnt - d0, 1);
    check("wrap_vec_len", bus.vec_len, 20);

    // Async reset mid-vector
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) push(200 + i, 1, 1'b0, t0);
    bus.stall = 1'b0;
    idle(3);
    bus.stall = 1'b1;
    check("pre_rst_level", bus.level, 2);
    check("pre_rst_valid", bus.m_valid, 1);
    check("pre_rst_a", bus.m_a, 202);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", bus.m_valid, 0);
    check("arst_a", bus.m_a, 0);
    check("arst_b", bus.m_b, 0);
    check("arst_level", bus.level, 0);
    check("arst_ready", bus.s_ready, 1);
    check("arst_len", bus.vec_len, 0);
    idle(2);
    reset = 1'b0;
    bus.stall = 1'b0;
    clear_log();
    push(1, 2, 1'b1, t0);
    idle(3);
    chk_seq("post_rst", 1, 1);
    check("post_rst_len", bus.vec_len, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
